// File: rtl/uart_pkg.sv
// Shared UART constants: data width, frame format and oversampling.
package uart_pkg;

   localparam int DATA_W     = 8;   // receiver data output width
   localparam int NBITS      = 8;   // data bits per frame
   localparam int OVERSAMPLE = 16;  // rx samples per bit period

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one async read port.
module uart_fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   // next array contents: only the addressed entry changes on a write
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   // storage is intentionally not reset; contents are qualified by the pointers
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer behind the UART receiver, with sticky overflow flag.
module uart_rx_fifo #(
   parameter int DATA_W = uart_pkg::DATA_W,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              clr_ovf
);

   import uart_pkg::*;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q,  count_d;
   logic              ovf_q,    ovf_d;
   logic              wr_acc, rd_acc, mem_we;
   logic [DATA_W-1:0] mem_rdata;

   // flags come straight from the count register, never from wr_en/rd_en
   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign count    = count_q;
   assign overflow = ovf_q;
   assign rd_data  = empty ? '0 : mem_rdata;

   // accept/next-state logic; a write into a full FIFO is allowed when a pop frees the slot
   always_comb begin
      rd_acc   = rd_en && !empty;
      wr_acc   = wr_en && (!full || rd_en);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (wr_acc && !rd_acc)      count_d = count_q + (ADDR_W+1)'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - (ADDR_W+1)'(1);
      // a dropped byte wins over a same-cycle clear so no overrun goes unreported
      if (wr_en && full && !rd_en) ovf_d = 1'b1;
      else if (clr_ovf)            ovf_d = 1'b0;
      mem_we = wr_acc && !reset;
   end

   // control registers; reset discards everything including same-cycle requests
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   uart_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (wr_data),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios then random traffic.
module tb_uart_rx_fifo;

   localparam int DW  = 8;
   localparam int DEP = 16;
   localparam int AW  = 4;

   logic          clk = 1'b0;
   logic          reset, wr_en, rd_en, clr_ovf;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_data;
   logic          empty, full, overflow;
   logic [AW:0]   count;

   uart_rx_fifo #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   // reference model: FIFO contents as a queue plus the sticky flag
   byte unsigned mq[$];
   bit           movf;
   // expected popped bytes, consumed by the monitor
   byte unsigned sb[$];
   // snapshot of the pre-edge state the monitor compares against
   int  exp_cnt, exp_head;
   bit  exp_ovf;
   bit  armed = 1'b0;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // one clock of stimulus; the model advances to the state after the coming edge
   task automatic step(input bit rst, input bit we, input byte unsigned wd,
                       input bit re, input bit co);
      bit do_rd, do_wr;
      @(posedge clk);
      #1;
      reset = rst; wr_en = we; wr_data = wd; rd_en = re; clr_ovf = co;
      exp_cnt  = mq.size();
      exp_head = (mq.size() != 0) ? int'(mq[0]) : 0;
      exp_ovf  = movf;
      if (rst) begin
         mq.delete();
         movf = 1'b0;
      end else begin
         do_rd = re && (mq.size() != 0);
         do_wr = we && ((mq.size() < DEP) || re);
         if (do_rd) sb.push_back(mq.pop_front());
         if (do_wr) mq.push_back(wd);
         if (we && mq.size() == DEP && !re && !do_wr) movf = 1'b1;
         else if (co) movf = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
   endtask

   task automatic wr(input byte unsigned d);
      step(0, 1, d, 0, 0);
   endtask

   task automatic pop(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 1, 0);
   endtask

   // monitor: status every cycle, popped data against the scoreboard
   always @(negedge clk) begin
      if (armed) begin
         chk("count",    int'(count),    exp_cnt);
         chk("empty",    int'(empty),    int'(exp_cnt == 0));
         chk("full",     int'(full),     int'(exp_cnt == DEP));
         chk("overflow", int'(overflow), int'(exp_ovf));
         chk("head",     int'(rd_data),  exp_head);
         if (rd_en && !empty && !reset) begin
            if (sb.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("pop_data", int'(rd_data), int'(sb.pop_front()));
         end
      end
   end

   initial begin
      reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; wr_data = '0;
      exp_cnt = 0; exp_head = 0; exp_ovf = 1'b0; movf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      armed = 1'b1;

      // reset values while idle
      idle(3);

      // three bytes in, three out in order
      wr(8'hA5); wr(8'h3C); wr(8'hFF);
      pop(3);
      idle(1);

      // fill to full, drop one, drain
      for (int i = 0; i < DEP; i++) wr(byte'(i));
      wr(8'h55);
      idle(1);
      pop(DEP);
      idle(1);
      step(0, 0, 8'h00, 0, 1);
      idle(1);

      // full with simultaneous write+read, pointer wrap on drain
      for (int i = 0; i < DEP; i++) wr(byte'(i));
      step(0, 1, 8'h77, 1, 0);
      idle(1);
      pop(DEP);
      idle(1);

      // empty with simultaneous write+read, then read on empty
      step(0, 1, 8'h42, 1, 0);
      idle(1);
      pop(1);
      step(0, 0, 8'h00, 1, 0);
      idle(1);

      // overflow set beats clear; clear alone works; reset mid-fill
      for (int i = 0; i < DEP + 1; i++) wr(byte'(8'h80 + i));
      step(0, 1, 8'h99, 0, 1);
      step(0, 0, 8'h00, 0, 1);
      idle(1);
      step(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 5; i++) wr(byte'(8'hC0 + i));
      step(1, 1, 8'hEE, 1, 0);
      idle(2);

      // random traffic, alternating fill-biased and drain-biased phases
      for (int ph = 0; ph < 12; ph++) begin
         for (int i = 0; i < 250; i++) begin
            bit r, w, rd, c;
            r  = ($urandom_range(0, 299) == 0);
            w  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 70 : 30));
            rd = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 70));
            c  = ($urandom_range(0, 19) == 0);
            step(r, w, byte'($urandom), rd, c);
         end
      end
      step(0, 0, 8'h00, 0, 0);
      @(posedge clk);
      #1;
      armed = 1'b0;
      chk("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
